// File: rtl/axi_resp_pkg.sv
// Shared AXI response codes and read-channel FSM states for the AXI slave responder.
package axi_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    localparam int LEN_WIDTH = 8;

endpackage

// File: rtl/axi_if.sv
// AXI bus bundle (AW, W, B, AR, R); modport s is the slave view used by the responder.
interface axi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5
);
    logic                    awvalid, awready;
    logic [ID_W_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid, wready, wlast;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [ID_W_WIDTH-1:0]   bid;
    logic [1:0]              bresp;
    logic                    arvalid, arready;
    logic [ID_R_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rvalid, rready, rlast;
    logic [ID_R_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport s (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous circular-buffer FIFO; push ignored when full, pop ignored when empty.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    // NOTE: storage is deliberately not reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/axi_slave_responder.sv
// AXI slave that accepts bursts, discards write data and returns tagged read data.
// Define AXI_SLAVE_WLAST_CHECK_EN to flag WLAST misuse with SLVERR and a sticky err_o.
module axi_slave_responder
    import axi_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_ID    = 0
) (
    input  logic clk_i,
    input  logic arstn_i,
    axi_if.s     s_axi_i,
    output logic idle_o,
    output logic err_o
);
    localparam int AW_W = ID_W_WIDTH + LEN_WIDTH;
    localparam int B_W  = ID_W_WIDTH + 2;
    localparam int AR_W = ID_R_WIDTH + LEN_WIDTH;
    localparam logic [7:0] RESP_TAG = RESP_ID[7:0];

    logic            aw_push, aw_pop, aw_full, aw_empty;
    logic [AW_W-1:0] aw_head;
    logic            b_push, b_pop, b_full, b_empty;
    logic [B_W-1:0]  b_head;
    logic            ar_push, ar_pop, ar_full, ar_empty;
    logic [AR_W-1:0] ar_head;

    logic [7:0] w_beat_q;
    logic       w_hs, w_final;
    resp_e      b_resp;

    r_state_e   state_q, state_d;
    logic [7:0] r_beat_q;
    logic       r_valid, r_last, r_hs;

    // ---------------- write path ----------------
    assign s_axi_i.awready = !aw_full;
    assign aw_push         = s_axi_i.awvalid && !aw_full;

    stream_fifo #(.WIDTH(AW_W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk_i, .arstn_i,
        .push(aw_push), .push_data({s_axi_i.awid, s_axi_i.awlen}), .full(aw_full),
        .pop(aw_pop), .pop_data(aw_head), .empty(aw_empty)
    );

    // W beats wait for their AW and for room to post the B response.
    assign s_axi_i.wready = !aw_empty && !b_full;
    assign w_hs           = s_axi_i.wvalid && s_axi_i.wready;
    assign w_final        = w_hs && (w_beat_q == aw_head[LEN_WIDTH-1:0]);
    assign aw_pop         = w_final;
    assign b_push         = w_final;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)     w_beat_q <= '0;
        else if (w_final) w_beat_q <= '0;
        else if (w_hs)    w_beat_q <= w_beat_q + 1'b1;
    end

`ifdef AXI_SLAVE_WLAST_CHECK_EN
    logic burst_err_q, err_q, beat_err;

    assign beat_err = w_hs && (s_axi_i.wlast != (w_beat_q == aw_head[LEN_WIDTH-1:0]));
    assign b_resp   = (burst_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            burst_err_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (w_final)       burst_err_q <= 1'b0;
            else if (beat_err) burst_err_q <= 1'b1;
            if (beat_err)      err_q       <= 1'b1;
        end
    end
`else
    assign b_resp = RESP_OKAY;
    assign err_o  = 1'b0;
`endif

    stream_fifo #(.WIDTH(B_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk_i, .arstn_i,
        .push(b_push), .push_data({aw_head[AW_W-1:LEN_WIDTH], b_resp}), .full(b_full),
        .pop(b_pop), .pop_data(b_head), .empty(b_empty)
    );

    assign s_axi_i.bvalid = !b_empty;
    assign s_axi_i.bid    = b_head[B_W-1:2];
    assign s_axi_i.bresp  = b_head[1:0];
    assign b_pop          = !b_empty && s_axi_i.bready;

    // ---------------- read path ----------------
    assign s_axi_i.arready = !ar_full;
    assign ar_push         = s_axi_i.arvalid && !ar_full;

    stream_fifo #(.WIDTH(AR_W), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk_i, .arstn_i,
        .push(ar_push), .push_data({s_axi_i.arid, s_axi_i.arlen}), .full(ar_full),
        .pop(ar_pop), .pop_data(ar_head), .empty(ar_empty)
    );

    assign r_last = (r_beat_q == ar_head[LEN_WIDTH-1:0]);
    assign r_hs   = r_valid && s_axi_i.rready;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= R_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        r_valid = 1'b0;
        ar_pop  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!ar_empty) state_d = R_BURST;
            end
            R_BURST: begin
                r_valid = 1'b1;
                if (s_axi_i.rready && r_last) begin
                    ar_pop  = 1'b1;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)  r_beat_q <= '0;
        else if (r_hs) r_beat_q <= r_last ? '0 : r_beat_q + 1'b1;
    end

    assign s_axi_i.rvalid = r_valid;
    assign s_axi_i.rid    = ar_head[AR_W-1:LEN_WIDTH];
    assign s_axi_i.rresp  = RESP_OKAY;
    assign s_axi_i.rdata  = DATA_WIDTH'({RESP_TAG, r_beat_q});
    assign s_axi_i.rlast  = r_valid && r_last;

    assign idle_o = aw_empty && b_empty && ar_empty && (state_q == R_IDLE) && (w_beat_q == '0);
endmodule

// File: doc/axi_slave_responder.md
AXI_SLAVE_RESPONDER -- requirements
Module: axi_slave_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning address width in bits.
REQ-003 SHALL have parameter ID_W_WIDTH, default 5, meaning AWID/BID width.
REQ-004 SHALL have parameter ID_R_WIDTH, default 5, meaning ARID/RID width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning depth of each request/response queue.
REQ-006 SHALL have parameter RESP_ID, default 0, meaning responder tag placed in RDATA.
REQ-007 SHALL have port clk_i  input  1  clock; all logic on its rising edge.
REQ-008 SHALL have port arstn_i  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port s_axi_i  axi_if.s  -  AXI slave port: AW, W, B, AR and R channels.
REQ-010 SHALL have port idle_o  output  1  high when no transaction is queued or in flight.
REQ-011 SHALL have port err_o  output  1  sticky WLAST protocol-error flag.

Function
REQ-012 AW: AWREADY = AW queue not full; an AW handshake pushes {AWID, AWLEN}.
REQ-013 W: WREADY = AW queue not empty AND B queue not full; W beats arriving before their AW stall.
REQ-014 8-bit W beat counter increments per W handshake; beat with counter == head AWLEN is final: counter -> 0, AW queue pops, B queue pushes {AWID, BRESP} in same cycle.
REQ-015 B: BVALID = B queue not empty; BID/BRESP from queue head; pop on BVALID & BREADY; first BVALID no earlier than 1 cycle after final W handshake.
REQ-016 AR: ARREADY = AR queue not full; an AR handshake pushes {ARID, ARLEN}.
REQ-017 R FSM states IDLE, BURST; IDLE -> BURST when AR queue not empty; BURST -> IDLE on RVALID & RREADY & RLAST (one bubble cycle between bursts).
REQ-018 In BURST: RVALID = 1, RID = head ARID, RRESP = OKAY, RDATA = {RESP_ID[7:0], beat index[7:0]} zero-extended to DATA_WIDTH, RLAST = (beat index == head ARLEN).
REQ-019 R beat index increments per R handshake; resets to 0 and pops AR queue on the last beat; RVALID held with stable payload while RREADY low.
REQ-020 Simultaneous push and pop on any non-full queue SHALL both take effect; occupancy unchanged.
REQ-021 AWLEN/ARLEN = 255 SHALL yield exactly 256 beats; counters SHALL not wrap mid-burst.
REQ-022 Write and read paths SHALL be fully independent; concurrent activity allowed.
REQ-023 idle_o = all queues empty AND R FSM in IDLE AND W beat counter == 0.
REQ-024 Address, AWSIZE/ARSIZE, AWBURST/ARBURST and WDATA/WSTRB SHALL be accepted and ignored.

Reset
REQ-025 On arstn_i low: queues empty, counters 0, R FSM IDLE, BVALID = RVALID = 0, err_o = 0, idle_o = 1.
REQ-026 Reset mid-burst SHALL abandon all pending transactions; no B or R issued for them.
REQ-027 AWREADY and ARREADY SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-028 Macro AXI_SLAVE_WLAST_CHECK_EN defined: WLAST on a non-final beat, or missing on the final beat, SHALL make that burst's BRESP = SLVERR (2'b10) and set err_o until reset.
REQ-029 Macro AXI_SLAVE_WLAST_CHECK_EN undefined: WLAST ignored, BRESP always OKAY (2'b00), err_o tied 0.

Structure
REQ-030 Shared package axi_resp_pkg SHALL hold the response codes (OKAY, SLVERR) and the R FSM state enum.
REQ-031 All three queues SHALL be instances of the existing stream_fifo sub-module; no other sub-modules.

Verification
REQ-032 Single write: AWID=3, AWLEN=3, 4 W beats with WLAST on the 4th -> one B with BID=3, BRESP=0, idle_o returns to 1.
REQ-033 Single read: ARID=7, ARLEN=2, RESP_ID=5, RREADY=1 -> 3 R beats with RDATA 0x500, 0x501, 0x502, RID=7, RLAST only on 3rd.
REQ-034 Backpressure: 5 AWs with BREADY=0 and FIFO_DEPTH=4 -> AWREADY low after 4 accepted; WREADY low once B queue full; all 5 B delivered in order after BREADY=1.
REQ-035 RREADY toggled every other cycle on ARLEN=7 -> 8 beats, payload stable while stalled, no lost or duplicated beat.
REQ-036 With AXI_SLAVE_WLAST_CHECK_EN: AWLEN=1, WLAST on beat 0 -> BRESP=2'b10, err_o=1 until reset; without the macro -> BRESP=0, err_o=0.
REQ-037 Reset asserted during a 16-beat read at beat 5 -> RVALID=0 next cycle, idle_o=1, no stale R after reset release.
